// File: rtl/controller_sequencer.sv
// Control unit for the 8-bit W-bus machine: one-hot T1..T6 ring plus opcode microcode decode.
// Latency: fixed 6 clocks per instruction; the control word is combinational from (t_state, opcode).
// Backpressure: none; the only stall is HLT, which parks the ring at T4 until rst.
//
// Ports:
//   clk      system clock, all state changes on posedge
//   rst      synchronous active-high reset, overrides halt and abandons the current instruction
//   opcode   IR upper nibble, must be stable from T4 to T6
//   t_state  one-hot ring state, bit0=T1 .. bit5=T6
//   cp, ep   PC increment / PC drives W-bus (active high)
//   lm_n     MAR load            ce_n  RAM drives W-bus
//   li_n     IR load             ei_n  IR address nibble drives W-bus
//   la_n     accumulator load    lb_n  B load        lo_n  output register load (all active low)
//   ea, eu   accumulator / adder drive W-bus (active high), su selects subtract
//   hlt      halt indicator, also gates the downstream clock enable
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_n,
  output logic       lo_n,
  output logic       hlt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  ring_e ring_q, ring_d;
  logic  halt_q, halt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q <= T1;
      halt_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      halt_q <= halt_d;
    end
  end

  // Next state. Any non-one-hot value falls into the default arm and
  // recovers to T1. Once halted the ring is parked at T4, so the T4 arm
  // alone keeps it there.
  always_comb begin
    ring_d = T1;
    halt_d = halt_q;
    case (ring_q)
      T1: ring_d = T2;
      T2: ring_d = T3;
      T3: ring_d = T4;
      T4: begin
        if (halt_q || opcode == OP_HLT) begin
          ring_d = T4;
          halt_d = 1'b1;
        end else begin
          ring_d = T5;
        end
      end
      T5: ring_d = T6;
      T6: ring_d = T1;
      default: ring_d = T1;
    endcase
  end

  // Control word. Everything starts inactive; each T-state pulls down only
  // the strobes it needs. While halted the word stays inactive apart from hlt.
  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    lm_n = 1'b1;
    ce_n = 1'b1;
    li_n = 1'b1;
    ei_n = 1'b1;
    la_n = 1'b1;
    ea   = 1'b0;
    su   = 1'b0;
    eu   = 1'b0;
    lb_n = 1'b1;
    lo_n = 1'b1;
    hlt  = halt_q;
    if (!halt_q) begin
      case (ring_q)
        T1: begin
          ep   = 1'b1;
          lm_n = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          ce_n = 1'b0;
          li_n = 1'b0;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ei_n = 1'b0;
            lm_n = 1'b0;
          end else if (opcode == OP_OUT) begin
            ea   = 1'b1;
            lo_n = 1'b0;
          end else if (opcode == OP_HLT) begin
            hlt  = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ce_n = 1'b0;
            la_n = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ce_n = 1'b0;
            lb_n = 1'b0;
            // Subtract mode is raised a cycle early so the adder output has
            // settled before the accumulator samples it in T6.
            su   = (opcode == OP_SUB);
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu   = 1'b1;
            la_n = 1'b0;
            su   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state = ring_q;

  // At most one W-bus driver per cycle.
  logic [4:0] bus_drv;
  assign bus_drv = {ep, ~ce_n, ~ei_n, ea, eu};

  a_bus_single_driver: assert property (@(posedge clk) disable iff (rst) $onehot0(bus_drv));

endmodule

// File: tb/tb_controller_sequencer.sv
module tb_controller_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [5:0] t_state;
  logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;

  controller_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .t_state(t_state),
    .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
    .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n), .hlt(hlt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;
  } cw_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: instruction step number 1..6 and a halted flag.
  int step   = 1;
  bit halted = 1'b0;

  // Tiny W-bus machine driven by the DUT strobes.
  bit         use_ir = 1'b0;
  logic [3:0] pc = 4'h0, mar = 4'h0;
  logic [7:0] ir = 8'h00, acc = 8'h00, breg = 8'h00, outr = 8'h00;
  logic [7:0] ram [16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (step %0d halted %0d t=%0t)", tag, obs, exp, step, halted, $time);
    end
  endtask

  function automatic cw_t model_cw(input int s, input bit h, input logic [3:0] op);
    cw_t w;
    bit  alu_op;
    w = 13'b0_0_1_1_1_1_1_0_0_0_1_1_0;
    alu_op = (op == 4'h1) || (op == 4'h2);
    if (h) begin
      w.hlt = 1'b1;
      return w;
    end
    case (s)
      1: begin w.ep = 1'b1; w.lm_n = 1'b0; end
      2: w.cp = 1'b1;
      3: begin w.ce_n = 1'b0; w.li_n = 1'b0; end
      4: begin
        if (op == 4'h0 || alu_op) begin w.ei_n = 1'b0; w.lm_n = 1'b0; end
        else if (op == 4'hE) begin w.ea = 1'b1; w.lo_n = 1'b0; end
        else if (op == 4'hF) w.hlt = 1'b1;
      end
      5: begin
        if (op == 4'h0) begin w.ce_n = 1'b0; w.la_n = 1'b0; end
        else if (alu_op) begin w.ce_n = 1'b0; w.lb_n = 1'b0; w.su = (op == 4'h2); end
      end
      6: begin
        if (alu_op) begin w.eu = 1'b1; w.la_n = 1'b0; w.su = (op == 4'h2); end
      end
      default: ;
    endcase
    return w;
  endfunction

  // One clock: drive inputs, compare outputs mid-cycle, step the model at the edge.
  task automatic tick(input bit r, input logic [3:0] op);
    cw_t        obs, exp;
    logic [5:0] exp_t;
    logic [7:0] bus;
    rst    = r;
    opcode = use_ir ? ir[7:4] : op;
    #1;
    exp   = model_cw(step, halted, opcode);
    exp_t = 6'b000001 << (step - 1);
    obs   = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt};
    check_eq("t_state", 32'(t_state), 32'(exp_t));
    check_eq("ctrl_word", 32'(obs), 32'(exp));
    if (ep)         bus = {4'h0, pc};
    else if (!ce_n) bus = ram[mar];
    else if (!ei_n) bus = {4'h0, ir[3:0]};
    else if (ea)    bus = acc;
    else if (eu)    bus = su ? acc - breg : acc + breg;
    else            bus = 8'h00;
    @(posedge clk);
    if (r) begin
      step = 1;
      halted = 1'b0;
      pc = 4'h0;
    end else begin
      if (!halted) begin
        if (step == 4 && opcode == 4'hF) halted = 1'b1;
        else step = (step % 6) + 1;
      end
      if (cp)    pc = pc + 4'h1;
      if (!lm_n) mar = bus[3:0];
      if (!li_n) ir = bus;
      if (!la_n) acc = bus;
      if (!lb_n) breg = bus;
      if (!lo_n) outr = bus;
    end
    #1;
  endtask

  // Run one instruction from T1. Opcode is noise until T4, then held.
  // abort_at (1..6) asserts rst in that step; 0 means no abort.
  task automatic run_instr(input logic [3:0] op, input int abort_at);
    int guard;
    bit r;
    guard = 0;
    do begin
      r = (abort_at != 0) && (step == abort_at);
      tick(r, (step >= 4) ? op : 4'($urandom));
      guard++;
    end while (!r && step != 1 && !halted && guard < 8);
  endtask

  task automatic park_then_reset(input int n);
    repeat (n) tick(1'b0, 4'($urandom));
    tick(1'b1, 4'($urandom));
  endtask

  initial begin
    int pick, abort;
    logic [3:0] op;

    // Two reset clocks, then the first tick checks the post-reset T1 word.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed: LDA, SUB, OUT, HLT (20 parked clocks), ADD aborted in T5, undefined 7.
    run_instr(4'h0, 0);
    run_instr(4'h2, 0);
    run_instr(4'hE, 0);
    run_instr(4'hF, 0);
    check_eq("halted_after_hlt", 32'(hlt), 32'(1));
    park_then_reset(20);
    run_instr(4'h1, 5);
    run_instr(4'h7, 0);
    run_instr(4'h7, 0);

    // Datapath program: acc = 7 - 3, output it, halt.
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram[0]  = 8'h09;
    ram[1]  = 8'h2A;
    ram[2]  = 8'hE0;
    ram[3]  = 8'hF0;
    ram[9]  = 8'h07;
    ram[10] = 8'h03;
    tick(1'b1, 4'h0);
    use_ir = 1'b1;
    run_instr(4'h0, 0);
    check_eq("acc_after_lda", 32'(acc), 32'(8'h07));
    run_instr(4'h0, 0);
    check_eq("acc_after_sub", 32'(acc), 32'(8'h04));
    run_instr(4'h0, 0);
    check_eq("out_reg", 32'(outr), 32'(8'h04));
    run_instr(4'h0, 0);
    check_eq("pc_at_halt", 32'(pc), 32'(4));
    park_then_reset(5);
    use_ir = 1'b0;

    // Randomized instruction stream with occasional mid-instruction reset.
    repeat (300) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    op = 4'h0;
        2, 3:    op = 4'h1;
        4, 5:    op = 4'h2;
        6:       op = 4'hE;
        7:       op = 4'hF;
        default: op = 4'($urandom_range(3, 13));
      endcase
      abort = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 6) : 0;
      run_instr(op, abort);
      if (halted) park_then_reset($urandom_range(1, 25));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
